// File: rtl/cpu_pkg.sv
// cpu_pkg: shared mul/div op encodings, FSM state encodings and default latencies
package cpu_pkg;
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;
    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;
endpackage

// File: rtl/muldiv.sv
// muldiv: HI/LO multiply-divide unit (clk, rst, start, op[2:0], a[31:0], b[31:0] in; busy, hi[31:0], lo[31:0] out)
module muldiv
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int CW = $clog2((MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1);
    md_state_e state;
    logic [CW-1:0] cnt;
    logic [31:0] ra, rb;
    logic sgn;
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, prod_s, prod_u;
    logic [31:0] q_s, r_s, q_u, r_u;
    assign sa = {{32{ra[31]}}, ra};
    assign sb = {{32{rb[31]}}, rb};
    assign ua = {32'b0, ra};
    assign ub = {32'b0, rb};
    assign prod_s = sa * sb;
    assign prod_u = ua * ub;
    // 64-bit signed divide makes 0x80000000 / -1 yield 0x80000000 rem 0 without overflow
    assign q_s = 32'(sa / sb);
    assign r_s = 32'(sa % sb);
    assign q_u = 32'(ua / ub);
    assign r_u = 32'(ua % ub);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    if (op == OP_MTHI) hi <= a;
                    else if (op == OP_MTLO) lo <= a;
                    else if (op <= OP_DIVU) begin
                        ra    <= a;
                        rb    <= b;
                        sgn   <= op == OP_MULT || op == OP_DIV;
                        cnt   <= op >= OP_DIV ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        state <= op >= OP_DIV ? ST_DIV : ST_MUL;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (state == ST_MUL) {hi, lo} <= sgn ? prod_s : prod_u;
                        else if (rb != '0) {hi, lo} <= sgn ? {r_s, q_s} : {r_u, q_u};
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: randomized self-checking bench for muldiv against an arithmetic reference model
module tb_muldiv;
    localparam int MC = 5;
    localparam int DC = 10;
    logic clk = 1'b0;
    logic rst, start, busy;
    logic [2:0] op;
    logic [31:0] a, b, hi, lo;
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    always #5 clk = ~clk;
    muldiv #(.MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            3'd0: begin
                longint p;
                p = longint'($signed(x)) * longint'($signed(y));
                {m_hi, m_lo} = p;
            end
            3'd1: {m_hi, m_lo} = {32'b0, x} * {32'b0, y};
            3'd2: if (y != 0) begin
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                    m_lo = x;
                    m_hi = '0;
                end else begin
                    m_lo = $signed(x) / $signed(y);
                    m_hi = $signed(x) % $signed(y);
                end
            end
            3'd3: if (y != 0) begin
                m_lo = x / y;
                m_hi = x % y;
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endfunction
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke);
        int n, exp_n;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        model(o, x, y);
        exp_n = o <= 3'd1 ? MC : o <= 3'd3 ? DC : 0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (poke) begin
                start = 1'b1;
                op = n == 1 ? 3'd5 : 3'($urandom_range(0, 7));
                a = n == 1 ? 32'h55 : $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check($sformatf("busy_len op%0d", o), 64'(n), 64'(exp_n));
        check($sformatf("hi op%0d", o), 64'(hi), 64'(m_hi));
        check($sformatf("lo op%0d", o), 64'(lo), 64'(m_lo));
    endtask
    initial begin
        rst = 1'b1; start = 1'b1; op = 3'd4; a = 32'h1234; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 64'(busy), 64'(0));
        check("rst hi", 64'(hi), 64'(0));
        check("rst lo", 64'(lo), 64'(0));
        rst = 1'b0; start = 1'b0;
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        check("mult vec", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
        check("multu vec", {hi, lo}, 64'h00000001_FFFFFFFE);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div vec", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("divu vec", {hi, lo}, 64'h00000001_7FFFFFFC);
        run_op(3'd4, 32'h1234, 32'd0, 1'b0);
        run_op(3'd3, 32'd7, 32'd0, 1'b0);
        check("div0 vec", {hi, lo}, {32'h1234, 32'h7FFFFFFC});
        run_op(3'd0, 32'd1000, 32'd3, 1'b1);
        check("ignored vec", {hi, lo}, 64'd3000);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div ovf vec", {hi, lo}, 64'h00000000_80000000);
        run_op(3'd6, 32'hDEAD, 32'd1, 1'b0);
        run_op(3'd7, 32'hBEEF, 32'd1, 1'b0);
        run_op(3'd5, 32'hCAFE, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_hi = '0; m_lo = '0;
        check("rst mid busy", 64'(busy), 64'(0));
        check("rst mid hi", 64'(hi), 64'(0));
        check("rst mid lo", 64'(lo), 64'(0));
        repeat (12) @(negedge clk);
        check("no late commit", {hi, lo}, 64'(0));
        check("no late busy", 64'(busy), 64'(0));
        for (int i = 0; i < 60; i++) begin
            logic [31:0] x, y;
            int sel;
            x = $urandom;
            sel = $urandom_range(0, 7);
            y = sel == 0 ? 32'd0 : sel == 1 ? 32'hFFFFFFFF : sel == 2 ? 32'd1 : $urandom;
            if ($urandom_range(0, 9) == 0) x = 32'h80000000;
            run_op(3'($urandom_range(0, 7)), x, y, 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, meaning busy length of MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy length of DIV/DIVU.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, meaning issue the operation on op this cycle.
REQ-006 SHALL have port op, input, 3, meaning 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved.
REQ-007 SHALL have port a, input, 32, meaning the rs operand from the register-file read port A.
REQ-008 SHALL have port b, input, 32, meaning the rt operand from the register-file read port B.
REQ-009 SHALL have port busy, output, 1, meaning a multiply/divide is in progress.
REQ-010 SHALL have port hi, output, 32, meaning the current HI register.
REQ-011 SHALL have port lo, output, 32, meaning the current LO register.

Function
REQ-012 SHALL use a three-state FSM: IDLE, MUL, DIV.
REQ-013 SHALL accept start only in IDLE with busy=0; start while busy, or with op 6-7, SHALL be ignored with no state change.
REQ-014 On an accepted MULT/MULTU/DIV/DIVU edge, SHALL latch a, b and op, load the counter with MUL_CYCLES or DIV_CYCLES, and enter MUL or DIV with busy=1 from the next cycle.
REQ-015 SHALL decrement the counter on each edge in MUL/DIV; on the edge where counter==1 it SHALL commit HI/LO, return to IDLE and drop busy, so busy is high exactly N cycles and the result is visible N cycles after the start edge.
REQ-016 MULT SHALL form the signed 64-bit product and MULTU the unsigned 64-bit product; HI gets bits 63:32 and LO bits 31:0.
REQ-017 DIV SHALL place the signed quotient, truncated toward zero, in LO and the remainder, signed like the dividend, in HI; DIVU SHALL do the same unsigned.
REQ-018 Divisor 0 SHALL still hold busy for DIV_CYCLES but leave HI/LO unchanged at completion.
REQ-019 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 with no other effect.
REQ-020 MTHI/MTLO accepted in IDLE SHALL write a into hi/lo at that edge (visible next cycle), set no busy and leave the other register unchanged.
REQ-021 Operands SHALL be taken only at the accepting edge; changes to a/b during busy SHALL not affect the result.
REQ-022 hi/lo SHALL be registered outputs and SHALL change only on a commit, on MTHI/MTLO, or on reset.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, counter=0, busy=0, hi=0 and lo=0, overriding start.
REQ-024 rst during MUL/DIV SHALL abandon the operation with no later commit.

Structure
REQ-025 Op encodings, FSM state encodings and default latencies SHALL live in shared package cpu_pkg, so decode logic uses the same values.
REQ-026 SHALL be a single module with no sub-module.
REQ-027 Multiply/divide SHALL be computed with 64-bit arithmetic on the latched operands, with the counter only modelling latency.

Verification
REQ-028 MULT a=0xFFFFFFFE, b=3 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 MULTU a=0xFFFFFFFF, b=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-030 DIV a=0xFFFFFFF9, b=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-031 MTHI 0x1234 then DIVU a=7, b=0 -> busy 10 cycles; HI=0x1234 and LO unchanged afterwards.
REQ-032 MULT issued, then MTLO 0x55 and a second start during busy -> both ignored; LO holds only the MULT result.
REQ-033 DIV issued, rst pulsed on its 3rd busy cycle -> next cycle busy=0, hi=lo=0; no commit 10 cycles later.
